// File: rtl/vga_ports.sv
// vga_ports: CPU I/O port block for a simple VGA-style display.
// Decodes the DAC index/data ports (0x3C7/0x3C8/0x3C9), the CRTC index/data
// pair (cursor position registers 0x0E/0x0F) and a one-bit video mode port.
// A completed R,G,B triple on the DAC data port becomes a one-cycle palette
// write pulse (pal_w) with pal_a/pal_d held for that cycle.
//
// Optional build macro: VGA_DAC_READ_EN
//   Defined   -> palette read-back through 0x3C7 (read index) and 0x3C9 reads.
//   Undefined -> 0x3C7 writes are ignored, 0x3C7/0x3C9 read as 8'hFF, the read
//                index stays 0 and no read-phase logic exists.
//
// Palette read-back note: pal_q is expected one cycle after pal_a. pal_a shows
// the read index except during a pal_w pulse, so the CPU should leave at least
// one idle cycle after a 0x3C7 write or a palette write before reading 0x3C9.

module vga_ports #(
    parameter logic [15:0] CRTC_BASE = 16'h03D4,
    parameter logic [15:0] MODE_PORT = 16'h03D8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] port_a,
    input  logic [7:0]  port_i,
    input  logic        port_w,
    input  logic        port_r,
    output logic [7:0]  port_o,
    output logic        videomode,
    output logic [11:0] cursor,
    output logic [7:0]  pal_a,
    output logic [11:0] pal_d,
    output logic        pal_w,
    input  logic [11:0] pal_q
);

    localparam logic [15:0] DAC_RD_IDX_PORT = 16'h03C7;
    localparam logic [15:0] DAC_WR_IDX_PORT = 16'h03C8;
    localparam logic [15:0] DAC_DATA_PORT   = 16'h03C9;
    localparam logic [15:0] CRTC_DATA       = CRTC_BASE + 16'd1;

    localparam logic [4:0]  CRTC_CUR_HI     = 5'h0E;
    localparam logic [4:0]  CRTC_CUR_LO     = 5'h0F;

    // Colour component sequence shared by the write and read sides.
    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    // ------------------------------------------------------------------
    // Strobe qualification and address decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_rd;
    logic w_sel_wrix;
    logic w_sel_data;
    logic w_sel_cidx;
    logic w_sel_cdat;
    logic w_sel_mode;

    // A write strobe wins: a coincident read is simply dropped.
    assign w_wr = port_w;
    assign w_rd = port_r & ~port_w;

    assign w_sel_wrix = (port_a == DAC_WR_IDX_PORT);
    assign w_sel_data = (port_a == DAC_DATA_PORT);
    assign w_sel_cidx = (port_a == CRTC_BASE);
    assign w_sel_cdat = (port_a == CRTC_DATA);
    assign w_sel_mode = (port_a == MODE_PORT);

    // ------------------------------------------------------------------
    // DAC write side: index, component phase and palette write pulse
    // ------------------------------------------------------------------
    phase_t      r_wr_phase;
    logic [7:0]  r_wr_idx;
    logic [3:0]  r_red;
    logic [3:0]  r_grn;
    logic        r_pal_w;
    logic [7:0]  r_pal_wa;
    logic [11:0] r_pal_d;

    // Collect R and G, then on B issue one palette write and step the index.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_phase <= PH_R;
            r_wr_idx   <= 8'h00;
            r_red      <= 4'h0;
            r_grn      <= 4'h0;
            r_pal_w    <= 1'b0;
            r_pal_wa   <= 8'h00;
            r_pal_d    <= 12'h000;
        end else begin
            r_pal_w <= 1'b0;
            if (w_wr && w_sel_wrix) begin
                r_wr_idx   <= port_i;
                r_wr_phase <= PH_R;
            end else if (w_wr && w_sel_data) begin
                case (r_wr_phase)
                    PH_R: begin
                        r_red      <= port_i[5:2];
                        r_wr_phase <= PH_G;
                    end
                    PH_G: begin
                        r_grn      <= port_i[5:2];
                        r_wr_phase <= PH_B;
                    end
                    PH_B: begin
                        r_pal_w    <= 1'b1;
                        r_pal_wa   <= r_wr_idx;
                        r_pal_d    <= {r_red, r_grn, port_i[5:2]};
                        r_wr_idx   <= r_wr_idx + 8'd1;
                        r_wr_phase <= PH_R;
                    end
                    default: begin
                        r_wr_phase <= PH_R;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // DAC read side (optional)
    // ------------------------------------------------------------------
    logic [7:0] w_rd_idx;

`ifdef VGA_DAC_READ_EN
    logic       w_sel_rdix;
    phase_t     r_rd_phase;
    logic [7:0] r_rd_idx;
    logic       r_rd_mode;
    logic [3:0] w_rd_comp;

    assign w_sel_rdix = (port_a == DAC_RD_IDX_PORT);
    assign w_rd_idx   = r_rd_idx;

    // Read index/phase tracking; r_rd_mode remembers which index port was last written.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_phase <= PH_R;
            r_rd_idx   <= 8'h00;
            r_rd_mode  <= 1'b0;
        end else begin
            if (w_wr && w_sel_rdix) begin
                r_rd_idx   <= port_i;
                r_rd_phase <= PH_R;
                r_rd_mode  <= 1'b1;
            end else if (w_wr && w_sel_wrix) begin
                r_rd_mode  <= 1'b0;
            end else if (w_rd && w_sel_data) begin
                case (r_rd_phase)
                    PH_R:    r_rd_phase <= PH_G;
                    PH_G:    r_rd_phase <= PH_B;
                    PH_B: begin
                        r_rd_phase <= PH_R;
                        r_rd_idx   <= r_rd_idx + 8'd1;
                    end
                    default: r_rd_phase <= PH_R;
                endcase
            end
        end
    end

    // Pick the 4-bit component of the palette entry for the current read phase.
    always_comb begin
        w_rd_comp = pal_q[11:8];
        case (r_rd_phase)
            PH_R:    w_rd_comp = pal_q[11:8];
            PH_G:    w_rd_comp = pal_q[7:4];
            PH_B:    w_rd_comp = pal_q[3:0];
            default: w_rd_comp = pal_q[11:8];
        endcase
    end
`else
    // Palette data is only consumed by the read-back path.
    logic w_unused_pal_q;

    assign w_rd_idx       = 8'h00;
    assign w_unused_pal_q = ^pal_q;
`endif

    // ------------------------------------------------------------------
    // CRTC index/cursor registers and video mode
    // ------------------------------------------------------------------
    logic [4:0]  r_crtc_idx;
    logic [11:0] r_cursor;
    logic        r_videomode;

    // CPU writes to the CRTC pair and the mode port.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_crtc_idx  <= 5'h00;
            r_cursor    <= 12'h000;
            r_videomode <= 1'b0;
        end else if (w_wr) begin
            if (w_sel_cidx) begin
                r_crtc_idx <= port_i[4:0];
            end else if (w_sel_cdat) begin
                if (r_crtc_idx == CRTC_CUR_HI) begin
                    r_cursor[11:8] <= port_i[3:0];
                end else if (r_crtc_idx == CRTC_CUR_LO) begin
                    r_cursor[7:0] <= port_i;
                end
            end else if (w_sel_mode) begin
                r_videomode <= port_i[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] w_rd_data;
    logic [7:0] r_port_o;

    // Read mux; 0x3C8 is write-only and, like unknown ports, reads 8'hFF.
    always_comb begin
        w_rd_data = 8'hFF;
        if (w_sel_cidx) begin
            w_rd_data = {3'b000, r_crtc_idx};
        end else if (w_sel_cdat) begin
            if (r_crtc_idx == CRTC_CUR_HI) begin
                w_rd_data = {4'h0, r_cursor[11:8]};
            end else if (r_crtc_idx == CRTC_CUR_LO) begin
                w_rd_data = r_cursor[7:0];
            end else begin
                w_rd_data = 8'h00;
            end
        end else if (w_sel_mode) begin
            w_rd_data = {7'h00, r_videomode};
`ifdef VGA_DAC_READ_EN
        end else if (w_sel_rdix) begin
            w_rd_data = r_rd_mode ? 8'h03 : 8'h00;
        end else if (w_sel_data) begin
            w_rd_data = {2'b00, w_rd_comp, w_rd_comp[3:2]};
`endif
        end
    end

    // Register read data on a qualified read; hold it otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_port_o <= 8'hFF;
        end else if (w_rd) begin
            r_port_o <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign port_o    = r_port_o;
    assign videomode = r_videomode;
    assign cursor    = r_cursor;
    assign pal_w     = r_pal_w;
    assign pal_d     = r_pal_d;
    // The palette address shows the write target only during the pulse.
    assign pal_a     = r_pal_w ? r_pal_wa : w_rd_idx;

endmodule

// File: tb/tb_vga_ports.sv
// tb_vga_ports: self-checking bench for vga_ports.
// Table-driven CRTC/mode vectors plus hand-written DAC sequences; read data and
// palette writes are checked through expectation queues popped by monitors.
module tb_vga_ports;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] port_a;
    logic [7:0]  port_i;
    logic        port_w;
    logic        port_r;
    logic [7:0]  port_o;
    logic        videomode;
    logic [11:0] cursor;
    logic [7:0]  pal_a;
    logic [11:0] pal_d;
    logic        pal_w;
    logic [11:0] pal_q;

    always #5 clock = ~clock;

    vga_ports dut (
        .clock     (clock),
        .reset     (reset),
        .port_a    (port_a),
        .port_i    (port_i),
        .port_w    (port_w),
        .port_r    (port_r),
        .port_o    (port_o),
        .videomode (videomode),
        .cursor    (cursor),
        .pal_a     (pal_a),
        .pal_d     (pal_d),
        .pal_w     (pal_w),
        .pal_q     (pal_q)
    );

    // Palette RAM model: registered read, written on pal_w.
    logic [11:0] pal_mem [256];
    always @(posedge clock) begin
        if (pal_w) pal_mem[pal_a] <= pal_d;
        pal_q <= pal_mem[pal_a];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboards
    typedef struct {
        logic [7:0]  a;
        logic [11:0] d;
    } pal_exp_t;
    pal_exp_t   pal_exp[$];
    logic [7:0] rd_exp[$];

    logic rd_seen = 1'b0;
    always @(posedge clock) rd_seen <= port_r & ~port_w & ~reset;

    // Compare read data and palette writes against the queued expectations.
    always @(negedge clock) begin
        if (rd_seen) begin
            if (rd_exp.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %h want no read result", port_o);
            end else begin
                check("port_o", {24'h0, port_o}, {24'h0, rd_exp.pop_front()});
            end
        end
        if (pal_w === 1'b1) begin
            if (pal_exp.size() == 0) begin
                total++; bad++;
                $display("FAIL pal_w_unexpected: got pal_a=%h pal_d=%h want no pulse", pal_a, pal_d);
            end else begin
                pal_exp_t e;
                e = pal_exp.pop_front();
                check("pal_a", {24'h0, pal_a}, {24'h0, e.a});
                check("pal_d", {20'h0, pal_d}, {20'h0, e.d});
            end
        end
    end

    task automatic pulse(input logic w, input logic r, input logic [15:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        port_a = a; port_i = d; port_w = w; port_r = r;
        @(posedge clock); #1;
        port_w = 1'b0; port_r = 1'b0; port_a = 16'h0000; port_i = 8'h00;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        pulse(1'b1, 1'b0, a, d);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] exp);
        rd_exp.push_back(exp);
        pulse(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic expect_pal(input logic [7:0] a, input logic [11:0] d);
        pal_exp_t e;
        e.a = a; e.d = d;
        pal_exp.push_back(e);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_o;
        logic [11:0] exp_cur;
        logic        exp_mode;
    } vec_t;

    vec_t vecs[20];

`ifdef VGA_DAC_READ_EN
    localparam logic [7:0] EXP_R = 8'h3F, EXP_G = 8'h00, EXP_B = 8'h22;
    localparam logic [7:0] EXP_RDIX_SET = 8'h03, EXP_RDIX_CLR = 8'h00, EXP_PAL_A = 8'h06;
`else
    localparam logic [7:0] EXP_R = 8'hFF, EXP_G = 8'hFF, EXP_B = 8'hFF;
    localparam logic [7:0] EXP_RDIX_SET = 8'hFF, EXP_RDIX_CLR = 8'hFF, EXP_PAL_A = 8'h00;
`endif

    initial begin
        vecs[0]  = '{1'b1, 16'h03D4, 8'h0E, 8'h00, 12'h000, 1'b0};
        vecs[1]  = '{1'b1, 16'h03D5, 8'h07, 8'h00, 12'h700, 1'b0};
        vecs[2]  = '{1'b1, 16'h03D4, 8'h0F, 8'h00, 12'h700, 1'b0};
        vecs[3]  = '{1'b1, 16'h03D5, 8'hD0, 8'h00, 12'h7D0, 1'b0};
        vecs[4]  = '{1'b0, 16'h03D5, 8'h00, 8'hD0, 12'h7D0, 1'b0};
        vecs[5]  = '{1'b0, 16'h03D4, 8'h00, 8'h0F, 12'h7D0, 1'b0};
        vecs[6]  = '{1'b1, 16'h03D4, 8'h0E, 8'h00, 12'h7D0, 1'b0};
        vecs[7]  = '{1'b0, 16'h03D5, 8'h00, 8'h07, 12'h7D0, 1'b0};
        vecs[8]  = '{1'b1, 16'h03D5, 8'hF3, 8'h00, 12'h3D0, 1'b0};
        vecs[9]  = '{1'b1, 16'h03D4, 8'h05, 8'h00, 12'h3D0, 1'b0};
        vecs[10] = '{1'b1, 16'h03D5, 8'hAA, 8'h00, 12'h3D0, 1'b0};
        vecs[11] = '{1'b0, 16'h03D5, 8'h00, 8'h00, 12'h3D0, 1'b0};
        vecs[12] = '{1'b1, 16'h03D4, 8'h3E, 8'h00, 12'h3D0, 1'b0};
        vecs[13] = '{1'b0, 16'h03D4, 8'h00, 8'h1E, 12'h3D0, 1'b0};
        vecs[14] = '{1'b0, 16'h1234, 8'h00, 8'hFF, 12'h3D0, 1'b0};
        vecs[15] = '{1'b1, 16'h03D8, 8'h03, 8'h00, 12'h3D0, 1'b1};
        vecs[16] = '{1'b0, 16'h03D8, 8'h00, 8'h01, 12'h3D0, 1'b1};
        vecs[17] = '{1'b1, 16'h03D8, 8'hFE, 8'h00, 12'h3D0, 1'b0};
        vecs[18] = '{1'b0, 16'h03D8, 8'h00, 8'h00, 12'h3D0, 1'b0};
        vecs[19] = '{1'b0, 16'h03D9, 8'h00, 8'hFF, 12'h3D0, 1'b0};

        reset = 1'b1; port_a = 16'h0; port_i = 8'h0; port_w = 1'b0; port_r = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_port_o", {24'h0, port_o}, 32'h0000_00FF);
        check("rst_videomode", {31'h0, videomode}, 32'h0);
        check("rst_cursor", {20'h0, cursor}, 32'h0);
        check("rst_pal_w", {31'h0, pal_w}, 32'h0);
        check("rst_pal_d", {20'h0, pal_d}, 32'h0);
        check("rst_pal_a", {24'h0, pal_a}, 32'h0);
        @(posedge clock); #1 reset = 1'b0;

        // CRTC / mode / unknown-port vectors
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
            else            do_read(vecs[i].a, vecs[i].exp_o);
            @(negedge clock);
            check($sformatf("vec%0d_cursor", i), {20'h0, cursor}, {20'h0, vecs[i].exp_cur});
            check($sformatf("vec%0d_mode", i), {31'h0, videomode}, {31'h0, vecs[i].exp_mode});
        end

        // One triple at 0x10, then a second triple lands at 0x11
        do_write(16'h03C8, 8'h10);
        do_write(16'h03C9, 8'h3F);
        do_write(16'h03C9, 8'h00);
        expect_pal(8'h10, 12'hF08);
        do_write(16'h03C9, 8'h20);
        do_write(16'h03C9, 8'h04);
        do_write(16'h03C9, 8'h08);
        expect_pal(8'h11, 12'h123);
        do_write(16'h03C9, 8'h0C);

        // Index wrap 0xFF -> 0x00
        do_write(16'h03C8, 8'hFF);
        do_write(16'h03C9, 8'h3C);
        do_write(16'h03C9, 8'h3C);
        expect_pal(8'hFF, 12'hFFF);
        do_write(16'h03C9, 8'h3C);
        do_write(16'h03C9, 8'h00);
        do_write(16'h03C9, 8'h04);
        expect_pal(8'h00, 12'h012);
        do_write(16'h03C9, 8'h08);

        // Palette read-back of entry 5
        do_write(16'h03C8, 8'h05);
        do_write(16'h03C9, 8'h3F);
        do_write(16'h03C9, 8'h00);
        expect_pal(8'h05, 12'hF08);
        do_write(16'h03C9, 8'h20);
        repeat (2) @(posedge clock);
        do_write(16'h03C7, 8'h05);
        do_read(16'h03C9, EXP_R);
        do_read(16'h03C9, EXP_G);
        do_read(16'h03C9, EXP_B);
        do_read(16'h03C7, EXP_RDIX_SET);
        @(negedge clock);
        check("rd_idx_after_b", {24'h0, pal_a}, {24'h0, EXP_PAL_A});
        do_write(16'h03C8, 8'h07);
        do_read(16'h03C7, EXP_RDIX_CLR);

        // Write+read together on the mode port: write only, port_o holds
        do_write(16'h03D8, 8'h00);
        do_read(16'h03D8, 8'h00);
        pulse(1'b1, 1'b1, 16'h03D8, 8'h01);
        @(negedge clock);
        check("wr_rd_mode", {31'h0, videomode}, 32'h1);
        check("wr_rd_port_o_held", {24'h0, port_o}, 32'h0);

        // Reset in the middle of a triple discards R and G
        do_write(16'h03C9, 8'h3C);
        do_write(16'h03C9, 8'h3C);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_mode", {31'h0, videomode}, 32'h0);
        check("mid_rst_cursor", {20'h0, cursor}, 32'h0);
        check("mid_rst_port_o", {24'h0, port_o}, 32'h0000_00FF);
        do_write(16'h03C9, 8'h04);
        do_write(16'h03C9, 8'h04);
        expect_pal(8'h00, 12'h111);
        do_write(16'h03C9, 8'h04);

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("pal_exp_drained", pal_exp.size(), 32'h0);
        check("rd_exp_drained", rd_exp.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_ports.md
VGA_PORTS -- requirements
Module: vga_ports

Interface
REQ-001 SHALL have parameter CRTC_BASE, default 16'h03D4, the CRTC index port; data port = CRTC_BASE+1.
REQ-002 SHALL have parameter MODE_PORT, default 16'h03D8, the video mode register port.
REQ-003 SHALL have ports, one per line:
  clock      in   1   single system clock, all logic on posedge
  reset      in   1   synchronous, active-high reset
  port_a     in   16  CPU I/O address
  port_i     in   8   CPU write data
  port_w     in   1   I/O write strobe, one cycle per access
  port_r     in   1   I/O read strobe, one cycle per access
  port_o     out  8   read data
  videomode  out  1   0 = 80x25 text, 1 = 320x200x256
  cursor     out  12  text cursor cell index, drives display stage cursor input
  pal_a      out  8   palette RAM address
  pal_d      out  12  palette write data {R4,G4,B4}
  pal_w      out  1   palette write enable, one-cycle pulse
  pal_q      in   12  palette RAM read data, valid one cycle after pal_a

Function
REQ-004 SHALL decode ports 0x3C7 (DAC read index), 0x3C8 (DAC write index), 0x3C9 (DAC data), CRTC_BASE, CRTC_BASE+1 and MODE_PORT; all other addresses SHALL be ignored and read as 8'hFF.
REQ-005 SHALL treat simultaneous port_w and port_r as a write only; the read SHALL be dropped.
REQ-006 Write to 0x3C8 SHALL load wr_idx <= port_i and wr_phase <= 0.
REQ-007 DAC write phases SHALL be WR_R -> WR_G -> WR_B -> WR_R, advancing on each 0x3C9 write; each phase SHALL latch port_i[5:2] as the 4-bit component.
REQ-008 On the WR_B write, the cycle after the strobe SHALL present pal_w=1, pal_a=wr_idx, and pal_d={R,G,port_i[5:2]}; wr_idx SHALL then increment, wrapping 255->0.
REQ-009 pal_w SHALL be high for exactly one cycle per completed triple and SHALL never assert on an R or G phase.
REQ-010 When pal_w=0, pal_a SHALL equal rd_idx.
REQ-011 Write to CRTC_BASE SHALL load crtc_idx <= port_i[4:0].
REQ-012 Write to CRTC_BASE+1 with crtc_idx=0x0E SHALL set cursor[11:8] <= port_i[3:0], with crtc_idx=0x0F SHALL set cursor[7:0] <= port_i, and with any other index SHALL be ignored.
REQ-013 Read of CRTC_BASE+1 SHALL return {4'h0,cursor[11:8]} for index 0x0E, cursor[7:0] for 0x0F, and 8'h00 otherwise.
REQ-014 Write to MODE_PORT SHALL set videomode <= port_i[0]; a read SHALL return {7'h0,videomode}.
REQ-015 port_o SHALL be registered and valid the cycle after port_r; otherwise it SHALL hold its last value.
REQ-016 Read of CRTC_BASE SHALL return {3'b0,crtc_idx}.

Reset
REQ-017 While reset is high: port_o=8'hFF, videomode=0, cursor=12'd0, pal_w=0, pal_d=0, pal_a=0, wr_idx=rd_idx=0, crtc_idx=0, both phases=R.
REQ-018 Reset asserted mid-triple SHALL discard the partial components; no pal_w SHALL follow.

Configuration
REQ-019 With VGA_DAC_READ_EN defined: write to 0x3C7 SHALL load rd_idx <= port_i and rd_phase <= R; each 0x3C9 read SHALL return {2'b00,c,c[3:2]} for the current component c of pal_q, advancing R->G->B; after B, rd_idx SHALL increment with 255->0 wrap. A read of 0x3C7 SHALL return {6'b0,2'b11} if the last DAC index write was 0x3C7, else {6'b0,2'b00}.
REQ-020 Without VGA_DAC_READ_EN: 0x3C7 writes SHALL be ignored, 0x3C7 and 0x3C9 reads SHALL return 8'hFF, rd_idx SHALL stay 0, and the read-phase logic SHALL not be synthesized.

Verification
REQ-021 Bench SHALL cover: write 0x3C8=0x10, then 0x3C9 = 0x3F, 0x00, 0x20 -> one pal_w pulse with pal_a=0x10, pal_d=12'hF08, and wr_idx=0x11.
REQ-022 Bench SHALL cover: write 0x3C8=0xFF, then six 0x3C9 writes -> pal_w at 0xFF, then at 0x00.
REQ-023 Bench SHALL cover: write 0x3D4=0x0E, 0x3D5=0x07, 0x3D4=0x0F, 0x3D5=0xD0 -> cursor=12'h7D0; a 0x3D5 read returns 0xD0.
REQ-024 Bench SHALL cover: two 0x3C9 writes, reset, then 0x3C9 = 0x04 three times -> exactly one pal_w, pal_d=12'h111, pal_a=0.
REQ-025 Bench SHALL cover, with VGA_DAC_READ_EN and palette[5]=12'hF08: write 0x3C7=5, then three 0x3C9 reads -> 0x3F, 0x00, 0x22; without the macro, the reads return 0xFF.
REQ-026 Bench SHALL cover: write MODE_PORT=0x01 with port_r also high -> videomode=1, port_o unchanged.
